// File: rtl/maxnet_output_check_n.sv
// maxnet_output_check_n
//   Convergence detector for the Maxnet datapath. It watches one snapshot of N
//   activation words per network iteration. It reports a winner when exactly
//   one activation is still non-zero, and it flags the all-dead and
//   iteration-budget cases. The result is held until the consumer accepts it
//   over a valid/ready handshake.
//
//   Optional feature macro: MAXNET_TIE_BREAK_EN
//     defined   : on timeout, report the alive channel with the largest
//                 magnitude (lowest index wins ties)
//     undefined : on timeout, winner/winner_idx are zero; only the timeout
//                 flag reports the outcome
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     start               begin an evaluation (accepted only in IDLE)
//     in_valid, x_flat    snapshot strobe and N x W activations
//     a_flat              N x LABEL_W channel labels
//     busy                evaluation in progress
//     result_valid        result held; result_ready accepts it
//     winner, winner_idx  selected label and channel index
//     none_alive, timeout outcome flags
//     iter_count          snapshots consumed in the current/last evaluation
module maxnet_output_check_n #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int LABEL_W  = 32,
  parameter int MAX_ITER = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [N*W-1:0]         x_flat,
  input  logic [N*LABEL_W-1:0]   a_flat,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [LABEL_W-1:0]     winner,
  output logic [$clog2(N)-1:0]   winner_idx,
  output logic                   none_alive,
  output logic                   timeout,
  output logic [15:0]            iter_count
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LABEL_W-1:0]   r_winner;
  logic [IDX_W-1:0]     r_winner_idx;
  logic                 r_none_alive;
  logic                 r_timeout;
  logic [15:0]          r_iter_count;

  logic [N-1:0]         w_alive;
  logic [CNT_W-1:0]     w_alive_cnt;
  logic [IDX_W-1:0]     w_low_idx;
  logic [N-1:0]         w_unused_sign;
  logic [15:0]          w_iter_inc;
  logic                 w_budget_hit;
  logic                 w_one_alive;
  logic                 w_zero_alive;
  logic                 w_snap;
  logic                 w_decide;
  logic [LABEL_W-1:0]   w_to_winner;
  logic [IDX_W-1:0]     w_to_idx;

  // Sign bits never affect liveness: +0 and -0 are both dead.
  always_comb begin
    w_alive       = '0;
    w_alive_cnt   = '0;
    w_low_idx     = '0;
    w_unused_sign = '0;
    for (int i = 0; i < N; i++) begin
      w_alive[i]       = |x_flat[i*W +: W-1];
      w_unused_sign[i] = x_flat[i*W + W-1];
      w_alive_cnt      = w_alive_cnt + CNT_W'(w_alive[i]);
    end
    // Descending scan so the lowest set index is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (w_alive[i]) w_low_idx = IDX_W'(i);
    end
  end

  assign w_iter_inc   = (r_iter_count == 16'hFFFF) ? r_iter_count : r_iter_count + 16'd1;
  assign w_budget_hit = (w_iter_inc == 16'(MAX_ITER));
  assign w_one_alive  = (w_alive_cnt == CNT_W'(1));
  assign w_zero_alive = (w_alive_cnt == '0);
  assign w_snap       = (r_state == S_RUN) && in_valid;
  // Convergence and all-dead take priority over the budget, so a snapshot
  // that converges on the last allowed iteration still reports a winner.
  assign w_decide     = w_snap && (w_one_alive || w_zero_alive || w_budget_hit);

`ifdef MAXNET_TIE_BREAK_EN
  logic [W-2:0]     w_best_mag;
  logic [IDX_W-1:0] w_best_idx;
  logic             w_found;

  // Strict greater-than keeps the earlier (lower) index on equal magnitudes.
  always_comb begin
    w_best_mag = '0;
    w_best_idx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_alive[i] && (!w_found || (x_flat[i*W +: W-1] > w_best_mag))) begin
        w_best_mag = x_flat[i*W +: W-1];
        w_best_idx = IDX_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign w_to_winner = a_flat[w_best_idx*LABEL_W +: LABEL_W];
  assign w_to_idx    = w_best_idx;
`else
  assign w_to_winner = '0;
  assign w_to_idx    = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_state_nxt = S_RUN;
      S_RUN:   if (w_decide)     w_state_nxt = S_DONE;
      // A start arriving with the handshake is dropped; IDLE sees the next one.
      S_DONE:  if (result_ready) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers only move on start or on a RUN snapshot, so they stay
  // frozen in DONE and hold through IDLE until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner     <= '0;
      r_winner_idx <= '0;
      r_none_alive <= 1'b0;
      r_timeout    <= 1'b0;
      r_iter_count <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_winner     <= '0;
      r_winner_idx <= '0;
      r_none_alive <= 1'b0;
      r_timeout    <= 1'b0;
      r_iter_count <= '0;
    end else if (w_snap) begin
      r_iter_count <= w_iter_inc;
      if (w_one_alive) begin
        r_winner     <= a_flat[w_low_idx*LABEL_W +: LABEL_W];
        r_winner_idx <= w_low_idx;
      end else if (w_zero_alive) begin
        r_none_alive <= 1'b1;
        r_winner     <= '0;
        r_winner_idx <= '0;
      end else if (w_budget_hit) begin
        r_timeout    <= 1'b1;
        r_winner     <= w_to_winner;
        r_winner_idx <= w_to_idx;
      end
    end
  end

  assign busy         = (r_state == S_RUN);
  assign result_valid = (r_state == S_DONE);
  assign winner       = r_winner;
  assign winner_idx   = r_winner_idx;
  assign none_alive   = r_none_alive;
  assign timeout      = r_timeout;
  assign iter_count   = r_iter_count;

endmodule

// File: tb/tb_maxnet_output_check_n.sv
module tb_maxnet_output_check_n;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 32;
  localparam int MI = 3;

  typedef logic [3:0][31:0] lanes_t;

  typedef struct {
    lanes_t      x;
    logic [31:0] w;
    logic [1:0]  idx;
    bit          none;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, result_ready;
  lanes_t          xs, as;
  logic [N*W-1:0]  x_flat;
  logic [N*LW-1:0] a_flat;
  logic            busy, result_valid, none_alive, timeout;
  logic [LW-1:0]   winner;
  logic [1:0]      winner_idx;
  logic [15:0]     iter_count;

  int errors = 0;
  int checks = 0;

  assign x_flat = xs;
  assign a_flat = as;

  always #5 clk = ~clk;

  maxnet_output_check_n #(.N(N), .W(W), .LABEL_W(LW), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .x_flat(x_flat), .a_flat(a_flat), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .winner(winner), .winner_idx(winner_idx), .none_alive(none_alive),
    .timeout(timeout), .iter_count(iter_count)
  );

  function automatic lanes_t mk(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input lanes_t x);
    xs = x;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk({tag, ".rv_drop"}, result_valid, 0);
    chk({tag, ".busy_idle"}, busy, 0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] w, input logic [1:0] idx,
                              input bit none, input bit to, input logic [15:0] it);
    chk({tag, ".rv"}, result_valid, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".winner"}, winner, w);
    chk({tag, ".idx"}, winner_idx, idx);
    chk({tag, ".none"}, none_alive, none);
    chk({tag, ".timeout"}, timeout, to);
    chk({tag, ".iter"}, iter_count, it);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rv"}, result_valid, 0);
    chk({tag, ".none"}, none_alive, 0);
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".winner"}, winner, 0);
    chk({tag, ".idx"}, winner_idx, 0);
    chk({tag, ".iter"}, iter_count, 0);
  endtask

  // Reference: outcome of the n_snap-th snapshot of an evaluation.
  function automatic void ref_eval(input lanes_t x, input lanes_t a, input int n_snap,
                                   output bit dec, output logic [31:0] w, output logic [1:0] idx,
                                   output bit none, output bit to);
    int cnt;
    int first;
    int best;
    logic [30:0] bm;
    cnt = 0; first = -1; best = -1; bm = '0;
    dec = 0; w = 0; idx = 0; none = 0; to = 0;
    for (int i = 0; i < N; i++) begin
      if (x[i][30:0] != 0) begin
        cnt++;
        if (first < 0) first = i;
        if (best < 0 || x[i][30:0] > bm) begin
          best = i;
          bm = x[i][30:0];
        end
      end
    end
    if (cnt == 1) begin
      dec = 1; w = a[first]; idx = 2'(first);
    end else if (cnt == 0) begin
      dec = 1; none = 1;
    end else if (n_snap == MI) begin
      dec = 1; to = 1;
`ifdef MAXNET_TIE_BREAK_EN
      w = a[best]; idx = 2'(best);
`endif
    end
  endfunction

  function automatic logic [31:0] rlane();
    case ($urandom_range(0, 4))
      0, 1:    return 32'h0;
      2:       return 32'h8000_0000;
      3:       return $urandom;
      default: return 32'($urandom_range(1, 3)) | ($urandom_range(0, 1) == 1 ? 32'h8000_0000 : 32'h0);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    lanes_t      labels;
    logic [31:0] ew;
    logic [1:0]  eidx;
    bit          edec, enone, eto;
    int          n;
    bit          decided;

    labels = mk(32'd10, 32'd20, 32'd30, 32'd40);
    tbl[0] = '{x: mk(32'h8000_0000, 0, 32'h3F80_0000, 0), w: 30, idx: 2, none: 0};
    tbl[1] = '{x: mk(0, 32'h8000_0000, 0, 0),             w: 0,  idx: 0, none: 1};
    tbl[2] = '{x: mk(0, 0, 0, 32'hFFFF_FFFF),             w: 40, idx: 3, none: 0};
    tbl[3] = '{x: mk(32'h1, 0, 32'h8000_0000, 32'h8000_0000), w: 10, idx: 0, none: 0};
    tbl[4] = '{x: mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), w: 0, idx: 0, none: 1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
    xs = '0; as = labels;
    tick(); tick();
    rst = 1'b0;
    check_reset("reset");

    // Convergence on the MAX_ITER-th snapshot is a winner, not a timeout.
    do_start();
    chk("conv.busy_rise", busy, 1);
    chk("conv.rv_low", result_valid, 0);
    snap(mk(5, 3, 2, 1));
    chk("conv.rv1", result_valid, 0);
    snap(mk(4, 0, 1, 0));
    chk("conv.rv2", result_valid, 0);
    chk("conv.busy2", busy, 1);
    snap(mk(0, 0, 7, 0));
    check_result("conv", 30, 2, 0, 0, 3);

    // Back-pressure: result frozen while inputs churn.
    for (int k = 0; k < 5; k++) begin
      xs = mk($urandom, $urandom, 0, 0);
      as = mk($urandom, $urandom, $urandom, $urandom);
      in_valid = 1'b1;
      tick();
      chk("bp.rv", result_valid, 1);
      chk("bp.winner", winner, 30);
      chk("bp.idx", winner_idx, 2);
      chk("bp.iter", iter_count, 3);
    end
    in_valid = 1'b0;
    as = labels;
    start = 1'b1; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp.hs_rv", result_valid, 0);
    chk("bp.start_ignored", busy, 0);
    tick();
    start = 1'b0;
    chk("bp.start2_busy", busy, 1);
    chk("bp.start2_iter", iter_count, 0);
    snap(mk(0, 32'h8000_0000, 0, 0));
    check_result("dead", 0, 0, 1, 0, 1);
    handshake("dead");

    // Single-snapshot vector table.
    foreach (tbl[i]) begin
      do_start();
      snap(tbl[i].x);
      check_result($sformatf("tbl%0d", i), tbl[i].w, tbl[i].idx, tbl[i].none, 0, 1);
      handshake($sformatf("tbl%0d", i));
    end

    // Timeout on the third snapshot.
    do_start();
    snap(mk(1, 9, 9, 2));
    chk("to.rv1", result_valid, 0);
    snap(mk(1, 9, 9, 2));
    chk("to.rv2", result_valid, 0);
    snap(mk(1, 9, 9, 2));
`ifdef MAXNET_TIE_BREAK_EN
    check_result("to", 20, 1, 0, 1, 3);
`else
    check_result("to", 0, 0, 0, 1, 3);
`endif
    handshake("to");

    // Reset mid-RUN.
    do_start();
    snap(mk(1, 9, 9, 2));
    snap(mk(1, 9, 9, 2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rstrun");
    do_start();
    chk("rstrun.iter0", iter_count, 0);
    chk("rstrun.busy", busy, 1);
    snap(mk(0, 5, 0, 0));
    check_result("rstrun.eval", 20, 1, 0, 0, 1);
    handshake("rstrun");

    // Reset mid-DONE.
    do_start();
    snap(mk(0, 0, 0, 8));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rstdone");

    // Randomized evaluations against the reference.
    for (int e = 0; e < 40; e++) begin
      do_start();
      n = 0;
      decided = 0;
      for (int cyc = 0; cyc < 50 && !decided; cyc++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
          chk("rnd.idle_busy", busy, 1);
          chk("rnd.idle_rv", result_valid, 0);
        end else begin
          lanes_t x;
          x = mk(rlane(), rlane(), rlane(), rlane());
          as = mk($urandom, $urandom, $urandom, $urandom);
          n++;
          ref_eval(x, as, n, edec, ew, eidx, enone, eto);
          snap(x);
          if (edec) begin
            decided = 1;
            as = mk($urandom, $urandom, $urandom, $urandom);
            check_result($sformatf("rnd%0d", e), ew, eidx, enone, eto, 16'(n));
          end else begin
            chk("rnd.rv_pending", result_valid, 0);
          end
        end
      end
      if (!decided) chk("rnd.no_decision", 0, 1);
      handshake("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
